// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: state encoding, load/store opcodes, default widths.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] OP_LWD = 8'd8;
    localparam logic [7:0] OP_LWI = 8'd9;
    localparam logic [7:0] OP_SWD = 8'd10;
    localparam logic [7:0] OP_SWI = 8'd11;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int WAIT_W     = 8;

endpackage

// File: rtl/data_mem_ctrl_mem_wait_counter.sv
// Per-access wait counter; terminal is high during the TERMINAL-th enabled cycle since the last clear.
module mem_wait_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between CPU and a busywait data memory.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES cycles.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RD_REQ,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              LOAD_WE,
    output logic              BUSYWAIT,
    output logic              ERROR,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSYWAIT,
    output logic [1:0]        DBG_STATE
);

    state_t state, next_state;
    logic   first_cycle;
    logic   last_rd;
    logic   timed_out;
    logic   timeout_hit;
    logic   in_access;
    logic   access_ok;
    logic   abort;

`ifdef MEM_TIMEOUT_EN
    mem_wait_counter #(
        .WIDTH    (WAIT_W),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_wait (
        .clk      (CLK),
        .rst_n    (RESET),
        .clear    (state == IDLE),
        .enable   (in_access),
        .terminal (timeout_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
`endif

    assign in_access = (state == READ) || (state == WRITE);
    // Memory busywait is registered, so it only means something from the second cycle.
    assign access_ok = in_access && !first_cycle && !MEM_BUSYWAIT;
    assign abort     = in_access && timeout_hit && !access_ok;

    always_comb begin
        next_state = state;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        LOAD_WE    = 1'b0;
        BUSYWAIT   = 1'b0;
        case (state)
            IDLE: begin
                BUSYWAIT = RESET && (RD_REQ || WR_REQ);
                if (RD_REQ) begin
                    next_state = READ;
                end else if (WR_REQ) begin
                    next_state = WRITE;
                end
            end
            READ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                if (access_ok || abort) next_state = DONE;
            end
            WRITE: begin
                MEM_WRITE = 1'b1;
                BUSYWAIT  = 1'b1;
                if (access_ok || abort) next_state = DONE;
            end
            DONE: begin
                LOAD_WE    = last_rd && !timed_out;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            first_cycle <= 1'b0;
            last_rd     <= 1'b0;
            timed_out   <= 1'b0;
            ERROR       <= 1'b0;
            RDATA       <= '0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
        end else begin
            state       <= next_state;
            first_cycle <= (state == IDLE) && (RD_REQ || WR_REQ);
            if (state == IDLE) begin
                if (RD_REQ) begin
                    MEM_ADDR  <= ADDR;
                    last_rd   <= 1'b1;
                    timed_out <= 1'b0;
                    if (WR_REQ) ERROR <= 1'b1;
                end else if (WR_REQ) begin
                    MEM_ADDR  <= ADDR;
                    MEM_WDATA <= WDATA;
                    last_rd   <= 1'b0;
                    timed_out <= 1'b0;
                end
            end
            if (access_ok && state == READ) begin
                RDATA <= MEM_RDATA;
            end
            if (abort) begin
                RDATA     <= '0;
                ERROR     <= 1'b1;
                timed_out <= 1'b1;
            end
        end
    end

    assign DBG_STATE = state;

endmodule
